// File: rtl/vec_assembler_if.sv
// Bundles the vec_assembler sub-vector input, weight strobe and {vector, weight} output handshake.
interface vec_assembler_if #(
    parameter int unsigned VECTOR_WIDTH = 920,
    parameter int unsigned BUS_WIDTH    = 512,
    parameter int unsigned CNT_WIDTH    = $clog2(VECTOR_WIDTH)
);
    logic [BUS_WIDTH-1:0]    sub_vector;
    logic                    sub_valid;
    logic [CNT_WIDTH-1:0]    cnt;
    logic                    cnt_new;
    logic [VECTOR_WIDTH-1:0] vector;
    logic [CNT_WIDTH-1:0]    weight;
    logic                    vec_valid;
    logic                    vec_ready;
    logic                    err;

    modport master (
        output sub_vector, sub_valid, cnt, cnt_new, vec_ready,
        input  vector, weight, vec_valid, err
    );

    modport slave (
        input  sub_vector, sub_valid, cnt, cnt_new, vec_ready,
        output vector, weight, vec_valid, err
    );
endinterface

// File: rtl/vec_assembler.sv
// Reassembles full vectors from sub-vector words and pairs each with its popcount weight.
// Optional sticky drop flag on err is compiled in when VEC_ASM_ERR_EN is defined.
module vec_assembler #(
    parameter int unsigned VECTOR_WIDTH  = 920,
    parameter int unsigned BUS_WIDTH     = 512,
    parameter int unsigned SUB_VECTOR_NO = 2,
    parameter int unsigned CNT_WIDTH     = $clog2(VECTOR_WIDTH)
) (
    input logic          clk,
    input logic          rstn,
    vec_assembler_if.slave bus
);
    localparam int unsigned ASM_W = SUB_VECTOR_NO * BUS_WIDTH;
    localparam int unsigned WCW   = (SUB_VECTOR_NO > 1) ? $clog2(SUB_VECTOR_NO) : 1;
    localparam logic [WCW-1:0] LAST_WORD = WCW'(SUB_VECTOR_NO - 1);

    logic [WCW-1:0]          word_cnt;
    logic [ASM_W-1:0]        asm_q;
    logic [ASM_W-1:0]        asm_next;
    logic                    pend_vld;
    logic [VECTOR_WIDTH-1:0] pend_vec;
    logic                    head_vld;
    logic [VECTOR_WIDTH-1:0] head_vec;
    logic [CNT_WIDTH-1:0]    head_wt;
    logic                    skid_vld;
    logic [VECTOR_WIDTH-1:0] skid_vec;
    logic [CNT_WIDTH-1:0]    skid_wt;

    logic                    done_c;
    logic [VECTOR_WIDTH-1:0] done_vec;
    logic                    push_c;
    logic [VECTOR_WIDTH-1:0] push_vec;
    logic                    pop_c;

    // Merge the incoming word so a vector is usable in the cycle its last word arrives.
    always_comb begin
        asm_next = asm_q;
        if (bus.sub_valid) begin
            asm_next[int'(word_cnt) * BUS_WIDTH +: BUS_WIDTH] = bus.sub_vector;
        end
        done_c   = bus.sub_valid && (word_cnt == LAST_WORD);
        done_vec = asm_next[VECTOR_WIDTH-1:0];
        // The weight always belongs to the oldest unweighted vector.
        push_c   = bus.cnt_new && (pend_vld || done_c);
        push_vec = pend_vld ? pend_vec : done_vec;
        pop_c    = head_vld && bus.vec_ready;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            word_cnt <= '0;
            asm_q    <= '0;
            pend_vld <= 1'b0;
            pend_vec <= '0;
            head_vld <= 1'b0;
            head_vec <= '0;
            head_wt  <= '0;
            skid_vld <= 1'b0;
            skid_vec <= '0;
            skid_wt  <= '0;
        end else begin
            if (bus.sub_valid) begin
                word_cnt <= done_c ? '0 : word_cnt + WCW'(1);
                asm_q    <= asm_next;
            end

            // New vector takes the slot unless it was weighted directly this cycle.
            if (done_c && !(bus.cnt_new && !pend_vld)) begin
                pend_vld <= 1'b1;
                pend_vec <= done_vec;
            end else if (bus.cnt_new && pend_vld) begin
                pend_vld <= 1'b0;
            end

            // Head register is the output stage; skid holds the second entry.
            if (pop_c) begin
                if (skid_vld) begin
                    head_vec <= skid_vec;
                    head_wt  <= skid_wt;
                    skid_vld <= push_c;
                    if (push_c) begin
                        skid_vec <= push_vec;
                        skid_wt  <= bus.cnt;
                    end
                end else begin
                    head_vld <= push_c;
                    if (push_c) begin
                        head_vec <= push_vec;
                        head_wt  <= bus.cnt;
                    end
                end
            end else if (push_c) begin
                if (!head_vld) begin
                    head_vld <= 1'b1;
                    head_vec <= push_vec;
                    head_wt  <= bus.cnt;
                end else if (!skid_vld) begin
                    skid_vld <= 1'b1;
                    skid_vec <= push_vec;
                    skid_wt  <= bus.cnt;
                end
            end
        end
    end

    assign bus.vector    = head_vec;
    assign bus.weight    = head_wt;
    assign bus.vec_valid = head_vld;

`ifdef VEC_ASM_ERR_EN
    logic err_q;
    logic drop_c;

    // Pending overwrite, orphan weight, or push into a full buffer with no pop.
    assign drop_c = (done_c && pend_vld && !bus.cnt_new)
                 || (bus.cnt_new && !pend_vld && !done_c)
                 || (push_c && head_vld && skid_vld && !pop_c);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            err_q <= 1'b0;
        end else if (drop_c) begin
            err_q <= 1'b1;
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

endmodule
